// File: rtl/lc3_mem_responder_if.sv
// rtl/lc3_mem_responder_if.sv - LC3 instruction/data/backdoor bus bundle for lc3_mem_responder
interface lc3_mem_responder_if;
  logic [15:0] pc;
  logic        instrmem_rd;
  logic [15:0] Instr_dout;
  logic        complete_instr;

  logic        Data_en;
  logic [15:0] Data_addr;
  logic        Data_rd;
  logic [15:0] Data_din;
  logic [15:0] Data_dout;
  logic        complete_data;

  logic        load_en;
  logic [15:0] load_addr;
  logic [15:0] load_data;
  logic        addr_err;

  modport master (
    output pc, instrmem_rd, Data_en, Data_addr, Data_rd, Data_din,
           load_en, load_addr, load_data,
    input  Instr_dout, complete_instr, Data_dout, complete_data, addr_err
  );

  modport slave (
    input  pc, instrmem_rd, Data_en, Data_addr, Data_rd, Data_din,
           load_en, load_addr, load_data,
    output Instr_dout, complete_instr, Data_dout, complete_data, addr_err
  );
endinterface

// File: rtl/lc3_mem_responder.sv
// rtl/lc3_mem_responder.sv - unified LC3 memory model with independent latency-programmable instruction and data ports
module lc3_mem_responder #(
  parameter logic [15:0] BASE_ADDR = 16'h3000,
  parameter int          DEPTH     = 256,
  parameter int          LAT_I     = 1,
  parameter int          LAT_D     = 2
) (
  input  logic                clock,
  input  logic                reset,
  lc3_mem_responder_if.slave  bus
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [16:0] END_ADDR = {1'b0, BASE_ADDR} + 17'(DEPTH);
  localparam logic [3:0]  LAT_I_M1 = 4'(LAT_I - 1);
  localparam logic [3:0]  LAT_D_M1 = 4'(LAT_D - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  function automatic logic in_range(input logic [15:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < END_ADDR);
  endfunction

  function automatic logic [AW-1:0] to_index(input logic [15:0] a);
    return AW'(a - BASE_ADDR);
  endfunction

  logic [15:0] r_mem [DEPTH];

  // Instruction port
  state_t      r_i_state, w_i_state_nxt;
  logic [3:0]  r_i_cnt, w_i_cnt_nxt;
  logic [15:0] r_i_addr, w_i_addr_nxt, w_i_acc_addr;
  logic        w_i_sample, w_i_fire, w_i_in;
  logic [15:0] w_i_rdata;
  logic        r_complete_instr;
  logic [15:0] r_instr_dout;

  // Data port
  state_t      r_d_state, w_d_state_nxt;
  logic [3:0]  r_d_cnt, w_d_cnt_nxt;
  logic [15:0] r_d_addr, w_d_addr_nxt, w_d_acc_addr;
  logic        r_d_rd, w_d_rd_nxt, w_d_acc_rd;
  logic [15:0] r_d_din, w_d_din_nxt, w_d_acc_din;
  logic        w_d_sample, w_d_fire, w_d_in, w_d_commit;
  logic [15:0] w_d_rdata;
  logic        r_complete_data;
  logic [15:0] r_data_dout;

  logic        w_ld_in;
  logic        w_err_set;
  logic        r_addr_err;

  always_comb begin
    w_i_state_nxt = r_i_state;
    w_i_cnt_nxt   = r_i_cnt;
    w_i_addr_nxt  = r_i_addr;
    w_i_acc_addr  = r_i_addr;
    w_i_fire      = 1'b0;
    w_i_sample    = bus.instrmem_rd && ((r_i_state == S_IDLE) || r_complete_instr);
    if (w_i_sample) begin
      w_i_addr_nxt = bus.pc;
      if (LAT_I == 1) begin
        // Single-cycle latency completes on the sample edge using the live address.
        w_i_fire      = 1'b1;
        w_i_acc_addr  = bus.pc;
        w_i_state_nxt = S_IDLE;
        w_i_cnt_nxt   = 4'd0;
      end else begin
        w_i_state_nxt = S_WAIT;
        w_i_cnt_nxt   = LAT_I_M1;
      end
    end else if (r_i_state == S_WAIT) begin
      if (!bus.instrmem_rd) begin
        w_i_state_nxt = S_IDLE;
        w_i_cnt_nxt   = 4'd0;
      end else if (r_i_cnt <= 4'd1) begin
        w_i_fire      = 1'b1;
        w_i_state_nxt = S_IDLE;
        w_i_cnt_nxt   = 4'd0;
      end else begin
        w_i_cnt_nxt = r_i_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_d_state_nxt = r_d_state;
    w_d_cnt_nxt   = r_d_cnt;
    w_d_addr_nxt  = r_d_addr;
    w_d_rd_nxt    = r_d_rd;
    w_d_din_nxt   = r_d_din;
    w_d_acc_addr  = r_d_addr;
    w_d_acc_rd    = r_d_rd;
    w_d_acc_din   = r_d_din;
    w_d_fire      = 1'b0;
    w_d_sample    = bus.Data_en && ((r_d_state == S_IDLE) || r_complete_data);
    if (w_d_sample) begin
      w_d_addr_nxt = bus.Data_addr;
      w_d_rd_nxt   = bus.Data_rd;
      w_d_din_nxt  = bus.Data_din;
      if (LAT_D == 1) begin
        w_d_fire      = 1'b1;
        w_d_acc_addr  = bus.Data_addr;
        w_d_acc_rd    = bus.Data_rd;
        w_d_acc_din   = bus.Data_din;
        w_d_state_nxt = S_IDLE;
        w_d_cnt_nxt   = 4'd0;
      end else begin
        w_d_state_nxt = S_WAIT;
        w_d_cnt_nxt   = LAT_D_M1;
      end
    end else if (r_d_state == S_WAIT) begin
      if (!bus.Data_en) begin
        w_d_state_nxt = S_IDLE;
        w_d_cnt_nxt   = 4'd0;
      end else if (r_d_cnt <= 4'd1) begin
        w_d_fire      = 1'b1;
        w_d_state_nxt = S_IDLE;
        w_d_cnt_nxt   = 4'd0;
      end else begin
        w_d_cnt_nxt = r_d_cnt - 4'd1;
      end
    end
  end

  assign w_i_in     = in_range(w_i_acc_addr);
  assign w_d_in     = in_range(w_d_acc_addr);
  assign w_ld_in    = in_range(bus.load_addr);
  assign w_i_rdata  = w_i_in ? r_mem[to_index(w_i_acc_addr)] : 16'h0000;
  assign w_d_rdata  = w_d_in ? r_mem[to_index(w_d_acc_addr)] : 16'h0000;
  assign w_d_commit = w_d_fire && !w_d_acc_rd && w_d_in && !reset;
  assign w_err_set  = (w_i_fire && !w_i_in) || (w_d_fire && !w_d_in) ||
                      (bus.load_en && !w_ld_in);

  // Backdoor load is placed last so it overrides a same-index data write.
  always_ff @(posedge clock) begin
    if (w_d_commit) begin
      r_mem[to_index(w_d_acc_addr)] <= w_d_acc_din;
    end
    if (bus.load_en && w_ld_in) begin
      r_mem[to_index(bus.load_addr)] <= bus.load_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_i_state        <= S_IDLE;
      r_i_cnt          <= 4'd0;
      r_i_addr         <= 16'h0000;
      r_complete_instr <= 1'b0;
      r_instr_dout     <= 16'h0000;
    end else begin
      r_i_state        <= w_i_state_nxt;
      r_i_cnt          <= w_i_cnt_nxt;
      r_i_addr         <= w_i_addr_nxt;
      r_complete_instr <= w_i_fire;
      if (w_i_fire) begin
        r_instr_dout <= w_i_rdata;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_d_state       <= S_IDLE;
      r_d_cnt         <= 4'd0;
      r_d_addr        <= 16'h0000;
      r_d_rd          <= 1'b0;
      r_d_din         <= 16'h0000;
      r_complete_data <= 1'b0;
      r_data_dout     <= 16'h0000;
    end else begin
      r_d_state       <= w_d_state_nxt;
      r_d_cnt         <= w_d_cnt_nxt;
      r_d_addr        <= w_d_addr_nxt;
      r_d_rd          <= w_d_rd_nxt;
      r_d_din         <= w_d_din_nxt;
      r_complete_data <= w_d_fire;
      if (w_d_fire && w_d_acc_rd) begin
        r_data_dout <= w_d_rdata;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr_err <= 1'b0;
    end else if (w_err_set) begin
      r_addr_err <= 1'b1;
    end
  end

  assign bus.Instr_dout     = r_instr_dout;
  assign bus.complete_instr = r_complete_instr;
  assign bus.Data_dout      = r_data_dout;
  assign bus.complete_data  = r_complete_data;
  assign bus.addr_err       = r_addr_err;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb/tb_lc3_mem_responder.sv - scoreboard bench for lc3_mem_responder with two latency configurations
module tb_lc3_mem_responder;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  lc3_mem_responder_if bus_a ();
  lc3_mem_responder_if bus_b ();

  lc3_mem_responder #(.BASE_ADDR(16'h3000), .DEPTH(256), .LAT_I(1), .LAT_D(3)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a));
  lc3_mem_responder #(.BASE_ADDR(16'h3000), .DEPTH(256), .LAT_I(2), .LAT_D(4)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b));

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q [$];
  logic [15:0] exp_v;
  int          lat;
  logic        seen;

  task automatic tick();
    @(negedge clock);
  endtask

  // sel: 0 a.instr, 1 a.data, 2 b.instr, 3 b.data
  task automatic wait_strobe(input int sel, output int n, output logic hit);
    n = 0;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clock);
      n++;
      case (sel)
        0:       hit = bus_a.complete_instr;
        1:       hit = bus_a.complete_data;
        2:       hit = bus_b.complete_instr;
        default: hit = bus_b.complete_data;
      endcase
    end
  endtask

  task automatic idle_inputs();
    bus_a.pc = 16'h0; bus_a.instrmem_rd = 1'b0; bus_a.Data_en = 1'b0; bus_a.Data_addr = 16'h0;
    bus_a.Data_rd = 1'b0; bus_a.Data_din = 16'h0; bus_a.load_en = 1'b0; bus_a.load_addr = 16'h0;
    bus_a.load_data = 16'h0;
    bus_b.pc = 16'h0; bus_b.instrmem_rd = 1'b0; bus_b.Data_en = 1'b0; bus_b.Data_addr = 16'h0;
    bus_b.Data_rd = 1'b0; bus_b.Data_din = 16'h0; bus_b.load_en = 1'b0; bus_b.load_addr = 16'h0;
    bus_b.load_data = 16'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    bus_a.load_en = 1'b1; bus_a.load_addr = 16'h3000; bus_a.load_data = 16'h1234;
    bus_b.load_en = 1'b1; bus_b.load_addr = 16'h3008; bus_b.load_data = 16'h7777;
    tick();
    bus_a.load_addr = 16'h3004; bus_a.load_data = 16'h5555;
    bus_b.load_en = 1'b0;
    tick();
    bus_a.load_en = 1'b0;
    tick();
    checks++; if (bus_a.complete_instr !== 1'b0) begin failures++; $display("FAIL reset_cinstr_a got=%b exp=0", bus_a.complete_instr); end
    checks++; if (bus_a.complete_data !== 1'b0) begin failures++; $display("FAIL reset_cdata_a got=%b exp=0", bus_a.complete_data); end
    checks++; if (bus_a.Instr_dout !== 16'h0000) begin failures++; $display("FAIL reset_idout_a got=%h exp=0000", bus_a.Instr_dout); end
    checks++; if (bus_a.Data_dout !== 16'h0000) begin failures++; $display("FAIL reset_ddout_a got=%h exp=0000", bus_a.Data_dout); end
    checks++; if (bus_a.addr_err !== 1'b0) begin failures++; $display("FAIL reset_err_a got=%b exp=0", bus_a.addr_err); end
    checks++; if ({bus_b.complete_instr, bus_b.complete_data, bus_b.addr_err} !== 3'b000) begin
      failures++; $display("FAIL reset_flags_b got=%b exp=000", {bus_b.complete_instr, bus_b.complete_data, bus_b.addr_err}); end
    checks++; if ({bus_b.Instr_dout, bus_b.Data_dout} !== 32'h0) begin
      failures++; $display("FAIL reset_douts_b got=%h exp=00000000", {bus_b.Instr_dout, bus_b.Data_dout}); end
  endtask

  task automatic test_instr_stream();
    reset = 1'b0;
    bus_a.pc = 16'h3000; bus_a.instrmem_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(16'h1234);
      wait_strobe(0, lat, seen);
      checks++; if (!seen || lat != 1) begin failures++; $display("FAIL istream_lat[%0d] got=%0d seen=%b exp=1", i, lat, seen); end
      exp_v = exp_q.pop_front();
      checks++; if (bus_a.Instr_dout !== exp_v) begin failures++; $display("FAIL istream_data[%0d] got=%h exp=%h", i, bus_a.Instr_dout, exp_v); end
    end
    bus_a.instrmem_rd = 1'b0;
    tick();
    checks++; if (bus_a.complete_instr !== 1'b0) begin failures++; $display("FAIL istream_stop got=%b exp=0", bus_a.complete_instr); end
    checks++; if (bus_a.Instr_dout !== 16'h1234) begin failures++; $display("FAIL istream_hold got=%h exp=1234", bus_a.Instr_dout); end
  endtask

  task automatic test_back_to_back();
    bus_a.Data_en = 1'b1; bus_a.Data_rd = 1'b0; bus_a.Data_addr = 16'h3010; bus_a.Data_din = 16'hBEEF;
    wait_strobe(1, lat, seen);
    checks++; if (!seen || lat != 3) begin failures++; $display("FAIL wr_lat got=%0d seen=%b exp=3", lat, seen); end
    checks++; if (bus_a.Data_dout !== 16'h0000) begin failures++; $display("FAIL wr_dout_hold got=%h exp=0000", bus_a.Data_dout); end
    bus_a.Data_rd = 1'b1; bus_a.Data_din = 16'h0000;
    exp_q.push_back(16'hBEEF);
    wait_strobe(1, lat, seen);
    checks++; if (!seen || lat != 3) begin failures++; $display("FAIL rd_lat got=%0d seen=%b exp=3", lat, seen); end
    exp_v = exp_q.pop_front();
    checks++; if (bus_a.Data_dout !== exp_v) begin failures++; $display("FAIL rd_data got=%h exp=%h", bus_a.Data_dout, exp_v); end
    bus_a.Data_en = 1'b0;
    tick();
    checks++; if (bus_a.complete_data !== 1'b0) begin failures++; $display("FAIL rd_stop got=%b exp=0", bus_a.complete_data); end
  endtask

  task automatic test_same_edge();
    bus_a.Data_en = 1'b1; bus_a.Data_rd = 1'b0; bus_a.Data_addr = 16'h3004; bus_a.Data_din = 16'h00AA;
    tick();
    tick();
    bus_a.instrmem_rd = 1'b1; bus_a.pc = 16'h3004;
    exp_q.push_back(16'h5555);
    tick();
    bus_a.Data_en = 1'b0;
    checks++; if ({bus_a.complete_instr, bus_a.complete_data} !== 2'b11) begin
      failures++; $display("FAIL same_edge_strobes got=%b exp=11", {bus_a.complete_instr, bus_a.complete_data}); end
    exp_v = exp_q.pop_front();
    checks++; if (bus_a.Instr_dout !== exp_v) begin failures++; $display("FAIL same_edge_old got=%h exp=%h", bus_a.Instr_dout, exp_v); end
    exp_q.push_back(16'h00AA);
    tick();
    exp_v = exp_q.pop_front();
    checks++; if (bus_a.complete_instr !== 1'b1 || bus_a.Instr_dout !== exp_v) begin
      failures++; $display("FAIL same_edge_new got=%h strobe=%b exp=%h", bus_a.Instr_dout, bus_a.complete_instr, exp_v); end
    bus_a.instrmem_rd = 1'b0;
    tick();
  endtask

  task automatic test_load_priority();
    bus_a.Data_en = 1'b1; bus_a.Data_rd = 1'b0; bus_a.Data_addr = 16'h3020; bus_a.Data_din = 16'h1111;
    tick();
    tick();
    bus_a.load_en = 1'b1; bus_a.load_addr = 16'h3020; bus_a.load_data = 16'h2222;
    tick();
    bus_a.load_en = 1'b0; bus_a.Data_en = 1'b0;
    checks++; if (bus_a.complete_data !== 1'b1) begin failures++; $display("FAIL ldpri_strobe got=%b exp=1", bus_a.complete_data); end
    tick();
    bus_a.Data_en = 1'b1; bus_a.Data_rd = 1'b1;
    exp_q.push_back(16'h2222);
    wait_strobe(1, lat, seen);
    bus_a.Data_en = 1'b0;
    exp_v = exp_q.pop_front();
    checks++; if (!seen || bus_a.Data_dout !== exp_v) begin failures++; $display("FAIL ldpri_data got=%h seen=%b exp=%h", bus_a.Data_dout, seen, exp_v); end
    tick();
  endtask

  task automatic test_addr_err();
    bus_a.load_en = 1'b1; bus_a.load_addr = 16'h30FF; bus_a.load_data = 16'hABCD;
    tick();
    bus_a.load_en = 1'b0;
    bus_a.instrmem_rd = 1'b1; bus_a.pc = 16'h30FF;
    exp_q.push_back(16'hABCD);
    wait_strobe(0, lat, seen);
    bus_a.instrmem_rd = 1'b0;
    exp_v = exp_q.pop_front();
    checks++; if (!seen || bus_a.Instr_dout !== exp_v) begin failures++; $display("FAIL top_word got=%h seen=%b exp=%h", bus_a.Instr_dout, seen, exp_v); end
    checks++; if (bus_a.addr_err !== 1'b0) begin failures++; $display("FAIL top_word_err got=%b exp=0", bus_a.addr_err); end
    tick();
    bus_a.instrmem_rd = 1'b1; bus_a.pc = 16'h2FFF;
    exp_q.push_back(16'h0000);
    wait_strobe(0, lat, seen);
    bus_a.instrmem_rd = 1'b0;
    exp_v = exp_q.pop_front();
    checks++; if (!seen || bus_a.Instr_dout !== exp_v) begin failures++; $display("FAIL below_base_data got=%h seen=%b exp=%h", bus_a.Instr_dout, seen, exp_v); end
    checks++; if (bus_a.addr_err !== 1'b1) begin failures++; $display("FAIL below_base_err got=%b exp=1", bus_a.addr_err); end
    repeat (3) tick();
    checks++; if (bus_a.addr_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", bus_a.addr_err); end
    bus_a.Data_en = 1'b1; bus_a.Data_rd = 1'b1; bus_a.Data_addr = 16'h3100;
    exp_q.push_back(16'h0000);
    wait_strobe(1, lat, seen);
    bus_a.Data_en = 1'b0;
    exp_v = exp_q.pop_front();
    checks++; if (!seen || bus_a.Data_dout !== exp_v) begin failures++; $display("FAIL above_top_data got=%h seen=%b exp=%h", bus_a.Data_dout, seen, exp_v); end
    tick();
  endtask

  task automatic test_abort();
    int strobes;
    bus_b.Data_en = 1'b1; bus_b.Data_rd = 1'b0; bus_b.Data_addr = 16'h3008; bus_b.Data_din = 16'h9999;
    tick();
    bus_b.Data_en = 1'b0;
    strobes = (bus_b.complete_data === 1'b1) ? 1 : 0;
    repeat (6) begin
      tick();
      if (bus_b.complete_data === 1'b1) strobes++;
    end
    checks++; if (strobes != 0) begin failures++; $display("FAIL abort_strobes got=%0d exp=0", strobes); end
    checks++; if (bus_b.Data_dout !== 16'h0000) begin failures++; $display("FAIL abort_dout got=%h exp=0000", bus_b.Data_dout); end
    bus_b.instrmem_rd = 1'b1; bus_b.pc = 16'h3008;
    for (int i = 1; i <= 6; i++) begin
      if (i % 2 == 1) exp_q.push_back(16'h7777);
      tick();
      checks++; if (bus_b.complete_instr !== ((i % 2) == 0)) begin
        failures++; $display("FAIL lat2_pattern[%0d] got=%b exp=%b", i, bus_b.complete_instr, (i % 2) == 0); end
      if (bus_b.complete_instr === 1'b1 && exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        checks++; if (bus_b.Instr_dout !== exp_v) begin failures++; $display("FAIL abort_unchanged[%0d] got=%h exp=%h", i, bus_b.Instr_dout, exp_v); end
      end
    end
    bus_b.instrmem_rd = 1'b0;
    exp_q.delete();
    tick();
  endtask

  task automatic test_reset_mid_wait();
    bus_a.Data_en = 1'b1; bus_a.Data_rd = 1'b0; bus_a.Data_addr = 16'h3010; bus_a.Data_din = 16'hDEAD;
    bus_a.instrmem_rd = 1'b1; bus_a.pc = 16'h3000;
    tick();
    checks++; if (bus_a.complete_instr !== 1'b1 || bus_a.Instr_dout !== 16'h1234) begin
      failures++; $display("FAIL prereset_instr got=%h strobe=%b exp=1234", bus_a.Instr_dout, bus_a.complete_instr); end
    reset = 1'b1;
    tick();
    checks++; if ({bus_a.complete_instr, bus_a.complete_data, bus_a.addr_err} !== 3'b000) begin
      failures++; $display("FAIL midreset_flags got=%b exp=000", {bus_a.complete_instr, bus_a.complete_data, bus_a.addr_err}); end
    checks++; if ({bus_a.Instr_dout, bus_a.Data_dout} !== 32'h0) begin
      failures++; $display("FAIL midreset_douts got=%h exp=00000000", {bus_a.Instr_dout, bus_a.Data_dout}); end
    bus_a.Data_en = 1'b0; bus_a.instrmem_rd = 1'b0;
    tick();
    reset = 1'b0;
    bus_a.instrmem_rd = 1'b1; bus_a.pc = 16'h3000;
    exp_q.push_back(16'h1234);
    wait_strobe(0, lat, seen);
    bus_a.instrmem_rd = 1'b0;
    exp_v = exp_q.pop_front();
    checks++; if (!seen || lat != 1 || bus_a.Instr_dout !== exp_v) begin
      failures++; $display("FAIL postreset_preload got=%h lat=%0d exp=%h", bus_a.Instr_dout, lat, exp_v); end
    bus_a.Data_en = 1'b1; bus_a.Data_rd = 1'b1; bus_a.Data_addr = 16'h3010;
    exp_q.push_back(16'hBEEF);
    wait_strobe(1, lat, seen);
    bus_a.Data_en = 1'b0;
    exp_v = exp_q.pop_front();
    checks++; if (!seen || lat != 3 || bus_a.Data_dout !== exp_v) begin
      failures++; $display("FAIL postreset_nowrite got=%h lat=%0d exp=%h", bus_a.Data_dout, lat, exp_v); end
    tick();
  endtask

  initial begin
    test_reset();
    test_instr_stream();
    test_back_to_back();
    test_same_edge();
    test_load_priority();
    test_addr_err();
    test_abort();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lc3_mem_responder.md
LC3_MEM_RESPONDER -- requirements
Module: lc3_mem_responder

Interface
REQ-001 Parameter BASE_ADDR, default 16'h3000, lowest word address mapped to storage.
REQ-002 Parameter DEPTH, default 256, number of 16-bit words stored; power of two, 2..4096.
REQ-003 Parameter LAT_I, default 1, instruction-read latency in cycles; legal range 1..15.
REQ-004 Parameter LAT_D, default 2, data-access latency in cycles; legal range 1..15.
REQ-005 clock  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 pc  in  16  instruction fetch address from LC3.
REQ-008 instrmem_rd  in  1  instruction read request, level-held by LC3.
REQ-009 Instr_dout  out  16  returned instruction word, registered.
REQ-010 complete_instr  out  1  one-cycle strobe; Instr_dout valid while high.
REQ-011 Data_en  in  1  data access request, level-held.
REQ-012 Data_addr  in  16  data word address.
REQ-013 Data_rd  in  1  1 = read, 0 = write; sampled with Data_en.
REQ-014 Data_din  in  16  write data from LC3.
REQ-015 Data_dout  out  16  read data returned to LC3, registered.
REQ-016 complete_data  out  1  one-cycle strobe ending a data access.
REQ-017 load_en  in  1  backdoor preload write enable.
REQ-018 load_addr  in  16  backdoor word address.
REQ-019 load_data  in  16  backdoor write data.
REQ-020 addr_err  out  1  sticky flag: an out-of-range address was accessed.

Function
REQ-021 Storage: one unified DEPTH x 16 array; address A maps when BASE_ADDR <= A < BASE_ADDR+DEPTH, index A-BASE_ADDR.
REQ-022 Each port has its own FSM, IDLE -> WAIT -> IDLE, and its own 4-bit down-counter.
REQ-023 Sample edge: any edge with request high while the FSM is IDLE or its complete strobe is high; this latches address (plus Data_rd/Data_din on the data port) and loads counter = LAT-1.
REQ-024 Completion: the complete strobe is high for exactly the one cycle following the edge at which the counter is 0 in WAIT, or following the sample edge when LAT=1.
REQ-025 With the request held continuously, LAT=1 gives complete high every cycle; LAT=N gives one completion every N cycles.
REQ-026 Request deasserted during WAIT aborts the access: FSM goes to IDLE, no strobe, no write, Data_dout/Instr_dout unchanged.
REQ-027 Reads return array contents at the completion edge; out-of-range reads return 16'h0000.
REQ-028 Writes commit to the array at the completion edge only; out-of-range writes are dropped.
REQ-029 Any out-of-range access, or out-of-range load_en, sets addr_err at its completion or load edge; only reset clears it.
REQ-030 Instruction read and data write to the same index on the same edge: the instruction read returns the pre-write value.
REQ-031 load_en writes load_data on the same edge, regardless of FSM state and including during reset.
REQ-032 load_en and a committing data write to the same index on the same edge: load_data wins.
REQ-033 Output data registers hold their value between completions.

Reset
REQ-034 Reset forces both FSMs to IDLE and sets counters to 0, complete_instr=0, complete_data=0, Instr_dout=16'h0000, Data_dout=16'h0000, addr_err=0.
REQ-035 Reset asserted mid-access aborts it: no strobe, no write.
REQ-036 Array contents are not cleared by reset.
REQ-037 The first sample edge is the first edge with reset low.

Verification
REQ-038 Preload 16'h1234 at 16'h3000, LAT_I=1, hold instrmem_rd=1, pc=16'h3000 -> complete_instr high the cycle after sampling, Instr_dout=16'h1234, repeats every cycle.
REQ-039 LAT_D=3, write 16'hBEEF to 16'h3010 then read it back -> each complete_data arrives 3 cycles after sampling, Data_dout=16'hBEEF.
REQ-040 Read at pc=16'h2FFF -> Instr_dout=16'h0000, addr_err=1 and stays 1 until reset.
REQ-041 Drop Data_en after 1 cycle of a LAT_D=4 write -> no complete_data, location unchanged.
REQ-042 Same edge: data write 16'h00AA and instruction read, both to 16'h3004 (old value 16'h5555) -> Instr_dout=16'h5555, later read returns 16'h00AA.
REQ-043 Assert reset mid-WAIT -> all outputs 0 the next cycle, preloaded words intact.
